// File: rtl/seg7_pkg.sv
// +-----------------------------------------------------------------------------
// | seg7_pkg : shared constants, state type and anode helper for the scan mux
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [6:0] SEG_ZERO   = 7'b0000001;
    localparam logic [7:0] AN_OFF     = 8'hFF;
    localparam int         NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [7:0] an_select(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_phase_timer.sv
// +-----------------------------------------------------------------------------
// | seg7_phase_timer : loadable down-counter that parks at zero and flags done
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module seg7_phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign done  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_mux.sv
// +-----------------------------------------------------------------------------
// | seg7_scan_mux : time-multiplexed 8-digit 7-segment driver with blanking gaps,
// |                 per-frame input snapshot and optional leading-zero blanking
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] HEX0,
    input  logic [6:0] HEX1,
    input  logic [6:0] HEX2,
    input  logic [6:0] HEX3,
    input  logic [6:0] HEX4,
    input  logic [6:0] HEX5,
    input  logic [6:0] HEX6,
    input  logic [6:0] HEX7,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic       frame_tick
);

    localparam int c_TMAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int c_TW   = $clog2(c_TMAX) + 1;
    localparam bit c_HAS_BLANK = (BLANK_CYCLES > 0);
    localparam bit c_ONE_CYCLE = (DIGIT_CYCLES == 1);
    localparam logic [c_TW-1:0] c_DIGIT_LOAD = c_TW'(DIGIT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_BLANK_LOAD = c_TW'(c_HAS_BLANK ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_TW-1:0] c_GAP_LOAD   = c_HAS_BLANK ? c_BLANK_LOAD : c_DIGIT_LOAD;

    state_t          r_state;
    logic [2:0]      r_idx;
    logic [6:0]      r_snap [NUM_DIGITS];
    logic [7:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_tick;

    logic [6:0]      w_hex      [NUM_DIGITS];
    logic [6:0]      w_snap_nxt [NUM_DIGITS];
    logic [2:0]      w_idx_nxt;
    logic            w_wrap;
    logic            w_cap;
    logic [7:0]      w_supp;
    logic            w_run;
    logic [7:0]      w_lit_an;
    logic [6:0]      w_lit_seg;
    logic            w_load;
    logic [c_TW-1:0] w_load_val;
    logic [c_TW-1:0] w_count;
    logic            w_done;

    assign w_hex[0] = HEX0;
    assign w_hex[1] = HEX1;
    assign w_hex[2] = HEX2;
    assign w_hex[3] = HEX3;
    assign w_hex[4] = HEX4;
    assign w_hex[5] = HEX5;
    assign w_hex[6] = HEX6;
    assign w_hex[7] = HEX7;

    // A fresh snapshot is taken on frame start and on the 7->0 wrap, so the
    // lit pattern for the next digit must come from the value being captured.
    assign w_wrap = (r_state == ST_SHOW) && w_done && (r_idx == 3'd7);
    assign w_cap  = en && ((r_state == ST_IDLE) || w_wrap);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_snap
        assign w_snap_nxt[k] = w_cap ? w_hex[k] : r_snap[k];
    end

    always_comb begin
        w_idx_nxt = r_idx;
        if (!en || r_state == ST_IDLE) begin
            w_idx_nxt = 3'd0;
        end else if (r_state == ST_SHOW && w_done) begin
            w_idx_nxt = r_idx + 3'd1;
        end
    end

    always_comb begin
        w_supp = '0;
        w_run  = (LZ_SUPPRESS != 0);
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_run     = w_run && (w_snap_nxt[k] == SEG_ZERO);
            w_supp[k] = w_run;
        end
    end

    assign w_lit_an  = w_supp[w_idx_nxt] ? AN_OFF  : an_select(w_idx_nxt);
    assign w_lit_seg = w_supp[w_idx_nxt] ? SEG_OFF : w_snap_nxt[w_idx_nxt];

    always_comb begin
        w_load     = 1'b0;
        w_load_val = c_DIGIT_LOAD;
        if (!en) begin
            w_load     = 1'b1;
            w_load_val = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_load     = 1'b1;
                    w_load_val = c_GAP_LOAD;
                end
                ST_BLANK: begin
                    w_load     = w_done;
                    w_load_val = c_DIGIT_LOAD;
                end
                ST_SHOW: begin
                    w_load     = w_done;
                    w_load_val = c_GAP_LOAD;
                end
                default: begin
                    w_load     = 1'b1;
                    w_load_val = '0;
                end
            endcase
        end
    end

    seg7_phase_timer #(
        .WIDTH    (c_TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .count    (w_count),
        .done     (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
            r_tick  <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_snap[k] <= SEG_OFF;
            end
        end else begin
            r_idx <= w_idx_nxt;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_snap[k] <= w_snap_nxt[k];
            end
            r_an   <= AN_OFF;
            r_seg  <= SEG_OFF;
            r_tick <= 1'b0;
            if (!en) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (c_HAS_BLANK) begin
                            r_state <= ST_BLANK;
                        end else begin
                            r_state <= ST_SHOW;
                            r_an    <= w_lit_an;
                            r_seg   <= w_lit_seg;
                        end
                    end
                    ST_BLANK: begin
                        if (w_done) begin
                            r_state <= ST_SHOW;
                            r_an    <= w_lit_an;
                            r_seg   <= w_lit_seg;
                            r_tick  <= (r_idx == 3'd7) && c_ONE_CYCLE;
                        end
                    end
                    ST_SHOW: begin
                        if (!w_done) begin
                            r_an   <= w_lit_an;
                            r_seg  <= w_lit_seg;
                            r_tick <= (r_idx == 3'd7) && (w_count == c_TW'(1));
                        end else if (c_HAS_BLANK) begin
                            r_state <= ST_BLANK;
                        end else begin
                            r_an   <= w_lit_an;
                            r_seg  <= w_lit_seg;
                            r_tick <= (w_idx_nxt == 3'd7) && c_ONE_CYCLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_tick;

    a_an_onehot_low: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~an));

endmodule

`default_nettype wire
